// File: rtl/apb_master.sv
`timescale 1ns/1ps
// apb_master
// Single-outstanding APB master. A command accepted on the cmd_* port
// becomes one APB transfer (SETUP, then one or more ACCESS cycles). A
// one-cycle response strobe reports the result of that transfer. An ACCESS
// phase that has not completed after TIMEOUT_CYCLES wait cycles is aborted
// and reported as a timeout.
//
// Handshake: a command transfers at a rising PCLK edge where cmd_valid=1
// and cmd_ready=1. cmd_ready is high only while the FSM is idle. A command
// offered while busy is not consumed and may be held until accepted.
// rsp_valid is a strobe that lasts one cycle and has no back-pressure.
// rsp_rdata, rsp_err and rsp_timeout stay valid until the next strobe.
//
// Parameters
//   ADDR_WIDTH      address width (default 32)
//   DATA_WIDTH      data width (default 32)
//   TIMEOUT_CYCLES  ACCESS cycles allowed before abort, legal 2..255
// Ports
//   PCLK, PRESET                     clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata command request channel
//   rsp_valid/rdata/err/timeout      response channel
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATA, PREADY, PSLVERR  APB
//   dbg_state                        current FSM state (debug observation)
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // The counter holds the number of ACCESS cycles already spent with
    // PREADY low. The timeout fires when the current cycle is also low and
    // the counter shows TIMEOUT_CYCLES-1 earlier wait cycles.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                state_q,   state_d;
    logic [7:0]            tmo_cnt_q, tmo_cnt_d;
    logic                  pwrite_q,  pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q,   paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q,  pwdata_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic                  err_q,     err_d;
    logic                  timeout_q, timeout_d;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            tmo_cnt_q <= '0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d  = ST_SETUP;
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                tmo_cnt_d = '0;
            end
            ST_ACCESS: begin
                // PREADY is tested first, so a slave that completes on the
                // last allowed cycle finishes normally instead of timing out.
                if (PREADY) begin
                    state_d   = ST_RESP;
                    rdata_d   = pwrite_q ? '0 : PRDATA;
                    err_d     = PSLVERR;
                    timeout_d = 1'b0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = ST_RESP;
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All control outputs are decoded from the registered state only.
    assign cmd_ready   = (state_q == ST_IDLE);
    assign PSEL        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign PENABLE     = (state_q == ST_ACCESS);
    assign rsp_valid   = (state_q == ST_RESP);
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = timeout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_apb_master.sv
`timescale 1ns/1ps
module tb_apb_master;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    // ---------------- clock / reset ----------------
    logic          PCLK      = 1'b0;
    logic          PRESET    = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [DW-1:0] PRDATA    = '0;
    logic          PREADY    = 1'b0;
    logic          PSLVERR   = 1'b0;
    logic          cmd_ready, rsp_valid, rsp_err, rsp_timeout;
    logic          PSEL, PENABLE, PWRITE;
    logic [DW-1:0] rsp_rdata, PWDATA;
    logic [AW-1:0] PADDR;
    logic [1:0]    dbg_state;

    always #5 PCLK = ~PCLK;

    apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int vectors     = 0;
    int miscompares = 0;
    logic [DW+1:0] exp_q[$];   // {timeout, err, rdata}
    int            len_q[$];   // expected ACCESS cycles

    logic          nxt_write;
    logic [AW-1:0] nxt_addr;
    logic [DW-1:0] nxt_wdata;

    // Reference model. The slave holds PREADY low for 'waits' ACCESS cycles
    // and then raises it. If the slave would make the master wait TMO or more
    // cycles, the transfer is aborted instead.
    function automatic logic [DW+1:0] model_rsp(input logic wr, input int waits,
                                                input logic [DW-1:0] rd, input logic err);
        if (waits >= TMO) return {2'b11, {DW{1'b0}}};
        return {1'b0, err, (wr ? {DW{1'b0}} : rd)};
    endfunction

    function automatic int model_len(input int waits);
        return (waits >= TMO) ? TMO : waits + 1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic randomize_slave();
        PREADY  = 1'($urandom_range(0, 1));
        PSLVERR = 1'($urandom_range(0, 1));
        PRDATA  = $urandom;
    endtask

    // Runs one command, starting and ending at a negedge while the DUT is
    // idle. If chain is set, the command in nxt_* is driven with cmd_valid
    // held high as soon as this one is accepted.
    task automatic run_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int waits, input logic [DW-1:0] rd, input logic err,
                           input bit chain);
        logic [DW+1:0] exp_rsp;
        int            exp_len;
        int            n_acc;
        bit            left;
        exp_q.push_back(model_rsp(wr, waits, rd, err));
        len_q.push_back(model_len(waits));

        vectors++;
        if ({cmd_ready, PSEL, PENABLE} !== 3'b100) begin
            miscompares++;
            $display("FAIL idle_before_cmd: ready/psel/penable got %b want 100", {cmd_ready, PSEL, PENABLE});
        end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        randomize_slave();
        @(negedge PCLK);
        if (chain) begin
            cmd_write = nxt_write; cmd_addr = nxt_addr; cmd_wdata = nxt_wdata;
        end else begin
            cmd_valid = 1'b0; cmd_write = 1'($urandom_range(0, 1));
            cmd_addr = $urandom; cmd_wdata = $urandom;
        end
        vectors++;
        if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b1000) begin
            miscompares++;
            $display("FAIL setup_ctrl: psel/penable/ready/rsp_valid got %b want 1000",
                     {PSEL, PENABLE, cmd_ready, rsp_valid});
        end
        vectors++;
        if ({PWRITE, PADDR, PWDATA} !== {wr, addr, wdata}) begin
            miscompares++;
            $display("FAIL setup_bus: got w=%b a=%h d=%h want w=%b a=%h d=%h",
                     PWRITE, PADDR, PWDATA, wr, addr, wdata);
        end
        randomize_slave();
        @(negedge PCLK);

        n_acc = 0;
        left  = 1'b0;
        while (!left && n_acc < 300) begin
            if (PSEL === 1'b1 && PENABLE === 1'b1) begin
                vectors++;
                if ({PWRITE, PADDR, PWDATA, cmd_ready, rsp_valid} !== {wr, addr, wdata, 2'b00}) begin
                    miscompares++;
                    $display("FAIL access_hold: cycle %0d got w=%b a=%h d=%h rdy=%b rv=%b want w=%b a=%h d=%h rdy=0 rv=0",
                             n_acc, PWRITE, PADDR, PWDATA, cmd_ready, rsp_valid, wr, addr, wdata);
                end
                if (n_acc >= waits) begin
                    PREADY = 1'b1; PRDATA = rd; PSLVERR = err;
                end else begin
                    PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom_range(0, 1));
                end
                n_acc++;
                @(negedge PCLK);
            end else begin
                left = 1'b1;
            end
        end

        exp_rsp = exp_q.pop_front();
        exp_len = len_q.pop_front();
        vectors++;
        if (!left) begin
            miscompares++;
            $display("FAIL access_bound: still in ACCESS after %0d cycles, want %0d", n_acc, exp_len);
        end else begin
            if (n_acc != exp_len) begin
                miscompares++;
                $display("FAIL access_len: got %0d ACCESS cycles want %0d", n_acc, exp_len);
            end
            vectors++;
            if ({rsp_valid, PSEL, PENABLE, cmd_ready} !== 4'b1000) begin
                miscompares++;
                $display("FAIL resp_ctrl: rsp_valid/psel/penable/ready got %b want 1000",
                         {rsp_valid, PSEL, PENABLE, cmd_ready});
            end
            vectors++;
            if ({rsp_timeout, rsp_err, rsp_rdata} !== exp_rsp) begin
                miscompares++;
                $display("FAIL resp_data: got tmo=%b err=%b rdata=%h want tmo=%b err=%b rdata=%h",
                         rsp_timeout, rsp_err, rsp_rdata, exp_rsp[DW+1], exp_rsp[DW], exp_rsp[DW-1:0]);
            end
            randomize_slave();
            @(negedge PCLK);
            vectors++;
            if ({rsp_valid, PSEL, PENABLE, cmd_ready} !== 4'b0001) begin
                miscompares++;
                $display("FAIL after_resp: rsp_valid/psel/penable/ready got %b want 0001",
                         {rsp_valid, PSEL, PENABLE, cmd_ready});
            end
            vectors++;
            if ({rsp_timeout, rsp_err, rsp_rdata} !== exp_rsp) begin
                miscompares++;
                $display("FAIL resp_hold: got tmo=%b err=%b rdata=%h want tmo=%b err=%b rdata=%h",
                         rsp_timeout, rsp_err, rsp_rdata, exp_rsp[DW+1], exp_rsp[DW], exp_rsp[DW-1:0]);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        // A command is offered on the same edges as reset and must be ignored.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = $urandom; cmd_wdata = $urandom;
        @(negedge PCLK);
        @(negedge PCLK);
        vectors++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, PADDR, PWDATA, rsp_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_values: psel=%b pen=%b pw=%b rv=%b err=%b tmo=%b a=%h d=%h rd=%h want all 0",
                     PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, PADDR, PWDATA, rsp_rdata);
        end
        PRESET = 1'b0; cmd_valid = 1'b0;
        @(negedge PCLK);
        vectors++;
        if ({cmd_ready, PSEL, PENABLE, rsp_valid} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_release: ready/psel/penable/rv got %b want 1000",
                     {cmd_ready, PSEL, PENABLE, rsp_valid});
        end
    endtask

    task automatic test_write_zero_wait();
        run_cmd(1'b1, 32'h0000_0008, 32'h0000_0005, 0, $urandom, 1'b0, 1'b0);
    endtask

    task automatic test_read_wait();
        run_cmd(1'b0, 32'h0000_0004, $urandom, 3, 32'h0000_00A5, 1'b0, 1'b0);
    endtask

    task automatic test_slave_err();
        run_cmd(1'b0, 32'h1000_0010, $urandom, 0, 32'h1234_5678, 1'b1, 1'b0);
        run_cmd(1'b1, 32'h2000_0000, 32'hCAFE_F00D, 2, $urandom, 1'b1, 1'b0);
    endtask

    task automatic test_timeout();
        run_cmd(1'b0, 32'h0000_0040, $urandom, TMO, 32'hDEAD_BEEF, 1'b0, 1'b0);
        run_cmd(1'b0, 32'h0000_0044, $urandom, TMO - 1, 32'h0BAD_F00D, 1'b0, 1'b0);
        run_cmd(1'b1, 32'h0000_0048, 32'h5555_AAAA, 200, $urandom, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        nxt_write = 1'b0; nxt_addr = 32'h0000_0100; nxt_wdata = $urandom;
        run_cmd(1'b1, 32'h0000_00F0, 32'h1111_2222, 2, $urandom, 1'b0, 1'b1);
        run_cmd(nxt_write, nxt_addr, nxt_wdata, 0, 32'h3333_4444, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        localparam int N = 14;
        logic          r_wr[N];
        logic [AW-1:0] r_addr[N];
        logic [DW-1:0] r_wdata[N];
        bit            r_chain;
        for (int i = 0; i < N; i++) begin
            r_wr[i] = 1'($urandom_range(0, 1)); r_addr[i] = $urandom; r_wdata[i] = $urandom;
        end
        for (int i = 0; i < N; i++) begin
            r_chain = (i < N - 1) && ($urandom_range(0, 1) == 1);
            if (r_chain) begin
                nxt_write = r_wr[i+1]; nxt_addr = r_addr[i+1]; nxt_wdata = r_wdata[i+1];
            end
            run_cmd(r_wr[i], r_addr[i], r_wdata[i], $urandom_range(0, 20), $urandom,
                    1'($urandom_range(0, 1)), r_chain);
        end
        // Leave a read with non-zero response fields for the reset test.
        run_cmd(1'b0, 32'h0000_0200, $urandom, 1, 32'hFFFF_0001, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0300; cmd_wdata = $urandom;
        PREADY = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        @(negedge PCLK);
        vectors++;
        if ({PSEL, PENABLE} !== 2'b11) begin
            miscompares++;
            $display("FAIL mid_in_access: psel/penable got %b want 11", {PSEL, PENABLE});
        end
        PRESET = 1'b1;
        @(negedge PCLK);
        vectors++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, PADDR, PWDATA, rsp_rdata} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_values: psel=%b pen=%b pw=%b rv=%b err=%b tmo=%b a=%h d=%h rd=%h want all 0",
                     PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, PADDR, PWDATA, rsp_rdata);
        end
        PRESET = 1'b0;
        PREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            vectors++;
            if ({rsp_valid, PSEL, cmd_ready} !== 3'b001) begin
                miscompares++;
                $display("FAIL mid_no_resp: cycle %0d rv/psel/ready got %b want 001", i, {rsp_valid, PSEL, cmd_ready});
            end
        end
        run_cmd(1'b1, 32'h0000_0304, 32'h7777_8888, 1, $urandom, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_slave_err();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
